// File: rtl/bist_controller.sv
// BIST run sequencer: seeds and steps an external PRPG, routes its patterns
// to the CUT, compacts the CUT responses into a MISR and compares the final
// signature against a golden value.
module bist_controller #(
  parameter int               WIDTH         = 4,
  parameter int               PATTERN_COUNT = 16,
  parameter int               CUT_LAT       = 1,
  parameter logic [WIDTH-1:0] MISR_POLY     = 'b0011,
  parameter int               CNT_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] golden_sig,
  input  logic [WIDTH-1:0] cut_resp,
  output logic             prpg_load,
  output logic             prpg_en,
  output logic             test_mode,
  output logic [CNT_W-1:0] pattern_cnt,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int FLUSH_W = (CUT_LAT > 1) ? $clog2(CUT_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    APPLY,
    FLUSH,
    COMPARE,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [CUT_LAT-1:0] pipe_q, pipe_d;
  logic [WIDTH-1:0]   misr_q, misr_d;
  logic               pass_q, pass_d;

  // Control outputs are pure decodes of the current state.
  assign prpg_load   = (state_q == SEED);
  assign prpg_en     = (state_q == APPLY);
  assign test_mode   = (state_q == SEED) || (state_q == APPLY) || (state_q == FLUSH);
  assign busy        = (state_q == SEED) || (state_q == APPLY) ||
                       (state_q == FLUSH) || (state_q == COMPARE);
  assign done        = (state_q == DONE);
  // The stored compare result is only meaningful while the run is finished.
  assign pass        = pass_q && (state_q == DONE);
  assign pattern_cnt = cnt_q;
  assign signature   = misr_q;

  // Next-state logic: sequencing, pattern counting, capture alignment, MISR.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    misr_d  = misr_q;
    pass_d  = pass_q;

    // Capture pipeline: an applied pattern reaches the last stage exactly
    // CUT_LAT cycles later, when its response is valid on cut_resp.
    pipe_d[0] = prpg_en;
    for (int i = 1; i < CUT_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (pipe_q[CUT_LAT-1]) begin
      misr_d = {misr_q[WIDTH-2:0], 1'b0} ^
               (misr_q[WIDTH-1] ? MISR_POLY : '0) ^ cut_resp;
    end

    unique case (state_q)
      IDLE: begin
        if (start) state_d = SEED;
      end
      SEED: begin
        cnt_d   = '0;
        flush_d = '0;
        pipe_d  = '0;
        misr_d  = '0;
        pass_d  = 1'b0;
        state_d = APPLY;
      end
      APPLY: begin
        if (cnt_q != CNT_W'(PATTERN_COUNT)) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PATTERN_COUNT - 1)) begin
          flush_d = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_q == FLUSH_W'(CUT_LAT - 1)) state_d = COMPARE;
        else                                  flush_d = flush_q + FLUSH_W'(1);
      end
      COMPARE: begin
        pass_d  = (misr_q == golden_sig);
        state_d = DONE;
      end
      DONE: begin
        if (start) state_d = SEED;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything: drop the run, discard in-flight captures
    // and freeze the MISR so the partial signature stays observable.
    if (abort) begin
      state_d = IDLE;
      pipe_d  = '0;
      misr_d  = misr_q;
      pass_d  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flush_q <= '0;
      pipe_q  <= '0;
      misr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together
      // from values sampled before the edge, avoiding order-dependent races.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      pipe_q  <= pipe_d;
      misr_q  <= misr_d;
      pass_q  <= pass_d;
    end
  end

endmodule
